// File: rtl/zood_pkg.sv
// Shared types and constants for the Zood code-breaking game sequencer.
package zood_pkg;

    localparam int PEG_W      = 3;
    localparam int NUM_PEGS   = 4;
    localparam int CODE_W     = 12;
    localparam int WIN_ZNARLY = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_GRADE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/zood_timeout_ctr.sv
// Loadable, saturating down-counter; expire is high while the count sits at zero.
module zood_timeout_ctr
    import zood_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/zood_game_sequencer.sv
// Game sequencer: accepts guesses, hands them to an external grader, tracks rounds and end-of-game status.
module zood_game_sequencer
    import zood_pkg::*;
#(
    parameter int MAX_ROUNDS    = 8,
    parameter int GRADE_TIMEOUT = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              loadMaster,
    input  logic [CODE_W-1:0] masterIn,
    input  logic              startGame,
    input  logic              abortGame,
    input  logic              guessValid,
    output logic              guessReady,
    input  logic [CODE_W-1:0] Guess,
    output logic              gradeStart,
    output logic [CODE_W-1:0] gradeGuess,
    output logic [CODE_W-1:0] gradeMaster,
    input  logic              gradeDone,
    input  logic [3:0]        gradeZnarly,
    input  logic [3:0]        gradeZood,
    output logic [3:0]        Znarly,
    output logic [3:0]        Zood,
    output logic [3:0]        RoundNumber,
    output logic              resultValid,
    output logic              gamePlaying,
    output logic              GameWon,
    output logic              GameOver,
    output logic              gradeError,
    output logic [2:0]        fsm_state
);

    localparam int         TW    = $clog2(GRADE_TIMEOUT + 1);
    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    state_t              state, state_n;
    logic [CODE_W-1:0]   master_q, master_n;
    logic                loaded, loaded_n;
    logic [CODE_W-1:0]   guess_n, gmaster_n;
    logic [3:0]          znarly_n, zood_n, round_n, round_inc;
    logic                won_n, err_n, valid_n;
    logic                expire;

    // Window opens in GRADE and counts the WAIT cycles; expire marks the last allowed cycle.
    zood_timeout_ctr #(.W(TW)) u_timeout (
        .clk       (CLOCK_50),
        .rst       (reset),
        .load      (state == ST_GRADE),
        .enable    (state == ST_WAIT),
        .load_value(TW'(GRADE_TIMEOUT - 1)),
        .expire    (expire)
    );

    assign round_inc = (RoundNumber >= MAX_R) ? MAX_R : RoundNumber + 4'd1;
    assign fsm_state = state;

    always_comb begin
        state_n   = state;
        master_n  = master_q;
        loaded_n  = loaded;
        guess_n   = gradeGuess;
        gmaster_n = gradeMaster;
        znarly_n  = Znarly;
        zood_n    = Zood;
        round_n   = RoundNumber;
        won_n     = GameWon;
        err_n     = gradeError;
        valid_n   = 1'b0;
        // Abort outranks every other request, including a same-cycle grade result.
        if (abortGame) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (loadMaster) begin
                        master_n = masterIn;
                        loaded_n = 1'b1;
                    end
                    if (startGame && loaded) begin
                        znarly_n = '0;
                        zood_n   = '0;
                        round_n  = '0;
                        won_n    = 1'b0;
                        err_n    = 1'b0;
                        state_n  = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (guessValid && guessReady) begin
                        guess_n   = Guess;
                        gmaster_n = master_q;
                        state_n   = ST_GRADE;
                    end
                end
                ST_GRADE: state_n = ST_WAIT;
                ST_WAIT: begin
                    // A result arriving on the expiry cycle still counts.
                    if (gradeDone) begin
                        znarly_n = gradeZnarly;
                        zood_n   = gradeZood;
                        round_n  = round_inc;
                        valid_n  = 1'b1;
                        if (gradeZnarly == 4'(WIN_ZNARLY)) begin
                            won_n   = 1'b1;
                            state_n = ST_OVER;
                        end else if (round_inc == MAX_R) begin
                            state_n = ST_OVER;
                        end else begin
                            state_n = ST_PLAY;
                        end
                    end else if (expire) begin
                        err_n   = 1'b1;
                        state_n = ST_OVER;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            master_q    <= '0;
            loaded      <= 1'b0;
            gradeGuess  <= '0;
            gradeMaster <= '0;
            Znarly      <= '0;
            Zood        <= '0;
            RoundNumber <= '0;
            GameWon     <= 1'b0;
            gradeError  <= 1'b0;
            resultValid <= 1'b0;
            gradeStart  <= 1'b0;
            guessReady  <= 1'b0;
            gamePlaying <= 1'b0;
            GameOver    <= 1'b0;
        end else begin
            state       <= state_n;
            master_q    <= master_n;
            loaded      <= loaded_n;
            gradeGuess  <= guess_n;
            gradeMaster <= gmaster_n;
            Znarly      <= znarly_n;
            Zood        <= zood_n;
            RoundNumber <= round_n;
            GameWon     <= won_n;
            gradeError  <= err_n;
            resultValid <= valid_n;
            gradeStart  <= (state_n == ST_GRADE);
            guessReady  <= (state_n == ST_PLAY);
            gamePlaying <= (state_n == ST_PLAY) || (state_n == ST_GRADE) || (state_n == ST_WAIT);
            GameOver    <= (state_n == ST_OVER);
        end
    end

endmodule

// File: doc/zood_game_sequencer.md
ZOOD_GAME_SEQUENCER -- requirements
Module: zood_game_sequencer

Interface
REQ-001 Parameter MAX_ROUNDS, default 8: rounds per game before GameOver.
REQ-002 Parameter GRADE_TIMEOUT, default 16: cycles allowed between gradeStart and gradeDone.
REQ-003 CLOCK_50  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 loadMaster  in  1  level; latch masterIn as the secret code.
REQ-006 masterIn  in  12  four 3-bit pegs, peg0 = [2:0].
REQ-007 startGame  in  1  request new game.
REQ-008 abortGame  in  1  abandon current game.
REQ-009 guessValid / guessReady  in / out  1 / 1  guess handshake.
REQ-010 Guess  in  12  guess pegs, same packing as masterIn.
REQ-011 gradeStart  out  1  one-cycle start pulse to the grader.
REQ-012 gradeGuess, gradeMaster  out  12 each  operands to the grader.
REQ-013 gradeDone  in  1  grader completion strobe.
REQ-014 gradeZnarly, gradeZood  in  4 each  grader results, valid with gradeDone.
REQ-015 Znarly, Zood  out  4 each  last registered result.
REQ-016 RoundNumber  out  4  completed rounds this game.
REQ-017 resultValid  out  1  one-cycle pulse when new result is on Znarly/Zood.
REQ-018 gamePlaying, GameWon, GameOver, gradeError  out  1 each  status.

Function
REQ-019 FSM states: IDLE, PLAY, GRADE, WAIT, OVER. All outputs registered.
REQ-020 loadMaster honoured only in IDLE or OVER: masterIn latched and masterLoaded set; ignored in other states.
REQ-021 startGame in IDLE or OVER with masterLoaded=1: clear RoundNumber, Znarly, Zood, GameWon, GameOver, gradeError; enter PLAY. With masterLoaded=0: ignored.
REQ-022 gamePlaying=1 in PLAY, GRADE, WAIT; else 0.
REQ-023 PLAY: guessReady=1; guessValid & guessReady latches Guess into gradeGuess, enter GRADE. guessReady=0 in all other states.
REQ-024 GRADE: gradeStart=1 for exactly one cycle (guess accepted cycle N -> gradeStart at N+1); enter WAIT; clear timeout counter.
REQ-025 gradeGuess and gradeMaster stable from GRADE until next guess accepted.
REQ-026 WAIT: on gradeDone, capture gradeZnarly/gradeZood into Znarly/Zood, RoundNumber+1, resultValid=1 on following cycle.
REQ-027 After capture: gradeZnarly==4 -> GameWon=1, OVER; else RoundNumber+1==MAX_ROUNDS -> OVER; else PLAY.
REQ-028 WAIT timeout: GRADE_TIMEOUT cycles without gradeDone -> gradeError=1, OVER; RoundNumber, Znarly, Zood unchanged.
REQ-029 gradeDone on the timeout-expiry cycle: gradeDone wins, no error.
REQ-030 gradeDone outside WAIT ignored.
REQ-031 OVER: GameOver=1 held until startGame or abortGame.
REQ-032 abortGame in any state -> IDLE next cycle; gamePlaying=0, GameOver=0; Znarly/Zood/RoundNumber retained; masterLoaded retained. abortGame beats startGame and gradeDone same cycle.
REQ-033 RoundNumber never exceeds MAX_ROUNDS; no wrap.

Reset
REQ-034 reset asserted: state IDLE, all outputs 0, master register 0, masterLoaded 0, timeout counter 0.
REQ-035 reset mid-WAIT discards in-flight grade; late gradeDone after release ignored (REQ-030).

Structure
REQ-036 Shared package zood_pkg: state enum, PEG_W=3, NUM_PEGS=4, CODE_W=12, WIN_ZNARLY=4.
REQ-037 One sub-module, zood_timeout_ctr: loadable down-counter with expire flag, used for REQ-028.

Verification
REQ-038 Load master 12'o1234, start, guess 12'o1234, gradeDone with Znarly=4 Zood=0 -> resultValid pulse, RoundNumber=1, GameWon=1, GameOver=1.
REQ-039 Eight non-winning guesses (Znarly=1, Zood=2) -> RoundNumber=8, GameOver=1, GameWon=0; ninth guessValid not accepted (guessReady=0).
REQ-040 Withhold gradeDone 16 cycles after gradeStart -> gradeError=1, OVER, RoundNumber unchanged; gradeDone on cycle 16 exactly -> no error.
REQ-041 startGame without prior loadMaster -> stays IDLE; loadMaster during PLAY -> gradeMaster unchanged.
REQ-042 abortGame and gradeDone same cycle in WAIT -> IDLE, no resultValid, RoundNumber unchanged.
REQ-043 reset asserted mid-WAIT, released, stray gradeDone -> all outputs remain 0, state IDLE.
